// File: rtl/ro_puf_pkg.sv
// Shared definitions for the RO PUF measurement path: FSM state encoding and
// the layout of the 6-bit challenge word.
package ro_puf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COUNT   = 2'd2,
        COMPARE = 2'd3
    } state_t;

    localparam int CHAL_W    = 6;
    localparam int SEL_W     = 3;
    localparam int SEL_A_LSB = 0;
    localparam int SEL_B_LSB = 3;

    function automatic logic [SEL_W-1:0] sel_field(input logic [CHAL_W-1:0] chal,
                                                   input int lsb);
        return chal[lsb +: SEL_W];
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One measurement channel: brings an asynchronous ring-oscillator output into
// the clk domain, detects rising edges and counts them with saturation.
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sig,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_count;
    logic             w_edge;
    logic             w_sat;

    // Two flops for metastability, a third to remember the last settled value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_prev;
    assign w_sat  = &r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && w_edge && !w_sat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ro_pair_counter.sv
// Drives the two RO mux selects from a challenge, counts both oscillators over
// a gate window and reports which one ran faster together with the raw counts.
module ro_pair_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    input  logic [WIN_W-1:0]  win_len,
    input  logic              mux_out_a,
    input  logic              mux_out_b,
    output logic [SEL_W-1:0]  sel_a,
    output logic [SEL_W-1:0]  sel_b,
    output logic              busy,
    output logic              done,
    output logic              response,
    output logic [CNT_W-1:0]  count_a,
    output logic [CNT_W-1:0]  count_b,
    output state_t            o_dbg_state
);
    // Handshake: start is a level request taken only in IDLE (ignored otherwise);
    // busy covers accept+1 up to but excluding the single-cycle done strobe,
    // and response/count_* are valid from done until the next done.
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [SET_W-1:0] r_settle_cnt;
    logic [WIN_W-1:0] r_win_len;
    logic [WIN_W-1:0] r_win_cnt;
    logic [SEL_W-1:0] r_sel_a;
    logic [SEL_W-1:0] r_sel_b;
    logic             r_done;
    logic             r_response;
    logic [CNT_W-1:0] r_count_a;
    logic [CNT_W-1:0] r_count_b;
    logic             w_accept;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_cnt_a;
    logic [CNT_W-1:0] w_cnt_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (r_settle_cnt == SET_W'(1)) begin
                    w_state_next = (r_win_len == '0) ? COMPARE : COUNT;
                end
            end
            COUNT: begin
                if (r_win_cnt == WIN_W'(1)) begin
                    w_state_next = COMPARE;
                end
            end
            COMPARE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // Holding the counters clear through SETTLE discards mux-switch glitches.
        w_cnt_clr = w_accept || (r_state == SETTLE);
        w_cnt_en  = (r_state == COUNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle_cnt <= '0;
            r_win_len    <= '0;
            r_win_cnt    <= '0;
            r_sel_a      <= '0;
            r_sel_b      <= '0;
        end else begin
            if (w_accept) begin
                r_settle_cnt <= SET_W'(SETTLE_CYC);
                r_win_len    <= win_len;
                r_sel_a      <= sel_field(challenge, SEL_A_LSB);
                r_sel_b      <= sel_field(challenge, SEL_B_LSB);
            end else if (r_state == SETTLE) begin
                r_settle_cnt <= r_settle_cnt - SET_W'(1);
            end
            if ((r_state == SETTLE) && (w_state_next == COUNT)) begin
                r_win_cnt <= r_win_len;
            end else if (r_state == COUNT) begin
                r_win_cnt <= r_win_cnt - WIN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done     <= 1'b0;
            r_response <= 1'b0;
            r_count_a  <= '0;
            r_count_b  <= '0;
        end else begin
            r_done <= (r_state == COMPARE);
            if (r_state == COMPARE) begin
                r_response <= (w_cnt_a > w_cnt_b);
                r_count_a  <= w_cnt_a;
                r_count_b  <= w_cnt_b;
            end
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk     (clk),
        .rst     (rst),
        .i_sig   (mux_out_a),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk     (clk),
        .rst     (rst),
        .i_sig   (mux_out_b),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_cnt_b)
    );

    assign sel_a       = r_sel_a;
    assign sel_b       = r_sel_b;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign response    = r_response;
    assign count_a     = r_count_a;
    assign count_b     = r_count_b;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ro_pair_counter.sv
// Self-checking bench for ro_pair_counter: a full-width instance plus a 4-bit
// counter instance for saturation, both fed the same synthetic RO waveforms.
module tb_ro_pair_counter;
  import ro_puf_pkg::*;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  challenge;
  logic [15:0] win_len;
  logic        mux_out_a = 1'b0;
  logic        mux_out_b = 1'b0;

  logic [2:0]  sel_a, sel_b, sel_a_s, sel_b_s;
  logic        busy, done, response, busy_s, done_s, response_s;
  logic [15:0] count_a, count_b;
  logic [3:0]  count_a_s, count_b_s;
  state_t      dbg_state, dbg_state_s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_start = 0;
  int half_a = 0;
  int half_b = 0;
  int ph_a = 0;
  int ph_b = 0;

  logic [32:0] exp_q[$];
  int          lat_q[$];

  ro_pair_counter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .win_len(win_len),
    .mux_out_a(mux_out_a), .mux_out_b(mux_out_b), .sel_a(sel_a), .sel_b(sel_b),
    .busy(busy), .done(done), .response(response), .count_a(count_a),
    .count_b(count_b), .o_dbg_state(dbg_state)
  );

  ro_pair_counter #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(S)) dut_s (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .win_len(win_len),
    .mux_out_a(mux_out_a), .mux_out_b(mux_out_b), .sel_a(sel_a_s), .sel_b(sel_b_s),
    .busy(busy_s), .done(done_s), .response(response_s), .count_a(count_a_s),
    .count_b(count_b_s), .o_dbg_state(dbg_state_s)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RO models: toggle every half_* cycles (period = 2*half), changing on negedge.
  always @(negedge clk) begin
    if (half_a > 0) begin
      ph_a = ph_a + 1;
      if (ph_a >= half_a) begin
        mux_out_a = ~mux_out_a;
        ph_a = 0;
      end
    end
    if (half_b > 0) begin
      ph_b = ph_b + 1;
      if (ph_b >= half_b) begin
        mux_out_b = ~mux_out_b;
        ph_b = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic set_rates(input int ha, input int hb);
    half_a = ha;
    half_b = hb;
    repeat (8) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic drive_start(input logic [5:0] chal, input logic [15:0] wl);
    start = 1'b1;
    challenge = chal;
    win_len = wl;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    challenge = 6'($urandom_range(0, 63));
    win_len = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_done(input int budget, output bit seen, output int t_done);
    seen = 1'b0;
    t_done = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        t_done = cyc;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    challenge = '0;
    win_len = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sel_a, sel_b, busy, done, response, count_a, count_b} !== '0) begin
      failures++;
      $display("FAIL reset_hold: sel_a=%0d sel_b=%0d busy=%b done=%b resp=%b ca=%0d cb=%0d want all 0",
               sel_a, sel_b, busy, done, response, count_a, count_b);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== IDLE || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: state=%0d busy=%b done=%b want IDLE/0/0", dbg_state, busy, done);
    end
  endtask

  task automatic test_a_faster();
    logic [32:0] e;
    int el, t0, td;
    bit seen;
    set_rates(2, 4);
    drive_start(6'b010_001, 16'd64);
    t0 = t_start;
    exp_q.push_back({1'b1, 16'd16, 16'd8});
    lat_q.push_back(S + 64 + 2);
    checks++;
    if (busy !== 1'b1 || sel_a !== 3'd1 || sel_b !== 3'd2 || dbg_state !== SETTLE) begin
      failures++;
      $display("FAIL a_fast_accept: busy=%b sel_a=%0d sel_b=%0d state=%0d want 1/1/2/SETTLE",
               busy, sel_a, sel_b, dbg_state);
    end
    wait_done(200, seen, td);
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (!seen || (td - t0) != el) begin
      failures++;
      $display("FAIL a_fast_latency: seen=%b got %0d want %0d", seen, td - t0, el);
    end
    checks++;
    if ({response, count_a, count_b} !== e || busy !== 1'b0) begin
      failures++;
      $display("FAIL a_fast_result: resp=%b ca=%0d cb=%0d busy=%b want resp=%b ca=%0d cb=%0d busy=0",
               response, count_a, count_b, busy, e[32], e[31:16], e[15:0]);
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({response, count_a, count_b} !== e || sel_a !== 3'd1 || sel_b !== 3'd2 || done !== 1'b0) begin
      failures++;
      $display("FAIL a_fast_hold: resp=%b ca=%0d cb=%0d sel_a=%0d sel_b=%0d done=%b",
               response, count_a, count_b, sel_a, sel_b, done);
    end
  endtask

  task automatic test_swap_tie();
    logic [32:0] e;
    int el, t0, td;
    bit seen;
    int ha_tab[2] = '{4, 2};
    int hb_tab[2] = '{2, 2};
    logic [32:0] exp_tab[2] = '{{1'b0, 16'd8, 16'd16}, {1'b0, 16'd16, 16'd16}};
    for (int k = 0; k < 2; k++) begin
      set_rates(ha_tab[k], hb_tab[k]);
      drive_start(6'b010_001, 16'd64);
      t0 = t_start;
      exp_q.push_back(exp_tab[k]);
      lat_q.push_back(S + 64 + 2);
      wait_done(200, seen, td);
      e = exp_q.pop_front();
      el = lat_q.pop_front();
      checks++;
      if (!seen || (td - t0) != el) begin
        failures++;
        $display("FAIL swap_tie_latency[%0d]: seen=%b got %0d want %0d", k, seen, td - t0, el);
      end
      checks++;
      if ({response, count_a, count_b} !== e) begin
        failures++;
        $display("FAIL swap_tie_result[%0d]: resp=%b ca=%0d cb=%0d want resp=%b ca=%0d cb=%0d",
                 k, response, count_a, count_b, e[32], e[31:16], e[15:0]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [32:0] e;
    int el, t0, td;
    bit seen;
    set_rates(1, 2);
    drive_start(6'b010_001, 16'd40);
    t0 = t_start;
    exp_q.push_back({1'b1, 16'd15, 16'd10});
    lat_q.push_back(S + 40 + 2);
    wait_done(200, seen, td);
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (!seen || (td - t0) != el || done_s !== 1'b1) begin
      failures++;
      $display("FAIL sat_latency: seen=%b done_s=%b got %0d want %0d", seen, done_s, td - t0, el);
    end
    checks++;
    if ({response_s, 12'd0, count_a_s, 12'd0, count_b_s} !== e) begin
      failures++;
      $display("FAIL sat_result: resp=%b ca=%0d cb=%0d want resp=%b ca=%0d cb=%0d",
               response_s, count_a_s, count_b_s, e[32], e[31:16], e[15:0]);
    end
    checks++;
    if (count_a !== 16'd20 || count_b !== 16'd10) begin
      failures++;
      $display("FAIL wide_unsat: ca=%0d cb=%0d want 20/10", count_a, count_b);
    end
  endtask

  task automatic test_zero_window();
    logic [32:0] e;
    int el, t0, td;
    bit seen;
    set_rates(2, 4);
    drive_start(6'b111_101, 16'd0);
    t0 = t_start;
    exp_q.push_back({1'b0, 16'd0, 16'd0});
    lat_q.push_back(S + 2);
    wait_done(50, seen, td);
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (!seen || (td - t0) != el) begin
      failures++;
      $display("FAIL zero_win_latency: seen=%b got %0d want %0d", seen, td - t0, el);
    end
    checks++;
    if ({response, count_a, count_b} !== e || sel_a !== 3'd5 || sel_b !== 3'd7) begin
      failures++;
      $display("FAIL zero_win_result: resp=%b ca=%0d cb=%0d sel_a=%0d sel_b=%0d want 0/0/0/5/7",
               response, count_a, count_b, sel_a, sel_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    int el, t0, td;
    bit seen;
    set_rates(2, 4);
    drive_start(6'b010_001, 16'd16);
    t0 = t_start;
    exp_q.push_back({1'b1, 16'd4, 16'd2});
    lat_q.push_back(S + 16 + 2);
    wait_done(100, seen, td);
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (!seen || (td - t0) != el || {response, count_a, count_b} !== e) begin
      failures++;
      $display("FAIL b2b_first: seen=%b lat=%0d resp=%b ca=%0d cb=%0d want lat=%0d 1/4/2",
               seen, td - t0, response, count_a, count_b, el);
    end
    // Still inside the done cycle: this start must be taken.
    drive_start(6'b001_010, 16'd8);
    t0 = t_start;
    exp_q.push_back({1'b1, 16'd2, 16'd1});
    lat_q.push_back(S + 8 + 2);
    checks++;
    if (busy !== 1'b1 || sel_a !== 3'd2 || sel_b !== 3'd1) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b sel_a=%0d sel_b=%0d want 1/2/1", busy, sel_a, sel_b);
    end
    wait_done(100, seen, td);
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (!seen || (td - t0) != el || {response, count_a, count_b} !== e) begin
      failures++;
      $display("FAIL b2b_second: seen=%b lat=%0d resp=%b ca=%0d cb=%0d want lat=%0d 1/2/1",
               seen, td - t0, response, count_a, count_b, el);
    end
  endtask

  task automatic test_ignore_start();
    logic [32:0] e;
    int el, t0, td;
    bit seen;
    set_rates(2, 4);
    drive_start(6'b010_001, 16'd64);
    t0 = t_start;
    exp_q.push_back({1'b1, 16'd16, 16'd8});
    lat_q.push_back(S + 64 + 2);
    repeat (10) @(negedge clk);
    start = 1'b1;
    challenge = 6'b001_010;
    win_len = 16'd5;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || sel_a !== 3'd1 || sel_b !== 3'd2 || dbg_state !== COUNT) begin
      failures++;
      $display("FAIL ignore_busy: busy=%b sel_a=%0d sel_b=%0d state=%0d want 1/1/2/COUNT",
               busy, sel_a, sel_b, dbg_state);
    end
    wait_done(200, seen, td);
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (!seen || (td - t0) != el || {response, count_a, count_b} !== e) begin
      failures++;
      $display("FAIL ignore_result: seen=%b lat=%0d resp=%b ca=%0d cb=%0d want lat=%0d 1/16/8",
               seen, td - t0, response, count_a, count_b, el);
    end
  endtask

  task automatic test_abort();
    logic [32:0] e;
    int el, t0, td;
    bit seen;
    set_rates(4, 2);
    drive_start(6'b001_010, 16'd64);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sel_a, sel_b, busy, done, response, count_a, count_b} !== '0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL abort_async_reset: sel_a=%0d sel_b=%0d busy=%b done=%b resp=%b ca=%0d cb=%0d state=%0d",
               sel_a, sel_b, busy, done, response, count_a, count_b, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_done(S + 64 + 10, seen, td);
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_no_done: done seen at cycle %0d want none", td);
    end
    drive_start(6'b001_010, 16'd32);
    t0 = t_start;
    exp_q.push_back({1'b0, 16'd4, 16'd8});
    lat_q.push_back(S + 32 + 2);
    wait_done(200, seen, td);
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (!seen || (td - t0) != el || {response, count_a, count_b} !== e) begin
      failures++;
      $display("FAIL abort_restart: seen=%b lat=%0d resp=%b ca=%0d cb=%0d want lat=%0d 0/4/8",
               seen, td - t0, response, count_a, count_b, el);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_a_faster();
    test_swap_tie();
    test_saturation();
    test_zero_window();
    test_back_to_back();
    test_ignore_start();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_pair_counter.md
# ro_pair_counter

Measurement stage that sits directly downstream of the two 8-to-1 ring-oscillator multiplexers in the RO PUF. It drives the `sel` inputs of mux A and mux B from a 6-bit challenge. It counts rising edges of each mux output over a programmable gate window. It then compares the two counts and returns a one-bit PUF response plus both raw counts.

## Interface
- `CNT_W`, default 16: width of each edge counter and of `count_a` / `count_b`.
- `WIN_W`, default 16: width of `win_len`.
- `SETTLE_CYC`, default 4: number of settle cycles after `sel` changes. Must be ≥3, which covers the 2-flop synchronizer plus the edge register.
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a measurement. Sampled only in IDLE.
- `challenge`, input, 6: bits [2:0] select ring oscillator A; bits [5:3] select ring oscillator B. Latched on an accepted `start`.
- `win_len`, input, WIN_W: gate window length in `clk` cycles. Latched on an accepted `start`.
- `mux_out_a`, input, 1: output of mux A. Asynchronous to `clk`.
- `mux_out_b`, input, 1: output of mux B. Asynchronous to `clk`.
- `sel_a`, output, 3: drives `sel` of mux A.
- `sel_b`, output, 3: drives `sel` of mux B.
- `busy`, output, 1: high from the cycle after an accepted `start` until the `done` cycle, exclusive of the `done` cycle.
- `done`, output, 1: one-cycle pulse when the result is valid.
- `response`, output, 1: 1 iff `count_a > count_b`.
- `count_a`, output, CNT_W: edge count of ring oscillator A for the last completed measurement.
- `count_b`, output, CNT_W: edge count of ring oscillator B for the last completed measurement.

## Operation
- **FSM states:** IDLE → SETTLE → COUNT → COMPARE → IDLE.
- **IDLE:** `start` high → latch `challenge` and `win_len`, load `sel_a`/`sel_b`, clear both counters, go to SETTLE.
- **SETTLE:** lasts exactly SETTLE_CYC cycles. Counters are held at 0 so that glitches from the mux switch are discarded.
- **COUNT:** lasts exactly `win_len` cycles. If `win_len` is 0, skip COUNT and go straight from SETTLE to COMPARE.
- **COMPARE:** lasts 1 cycle. Outputs are registered on the exit edge: `response = (cnt_a > cnt_b)`, `count_a = cnt_a`, `count_b = cnt_b`. `done` pulses and `busy` falls.
- **Edge detection, per channel:** 2-flop synchronizer, then a previous-value register. The edge pulse is `sync & ~prev`. A pulse increments the counter only while in COUNT.
- **Counter arithmetic:** saturates at 2^CNT_W − 1 and does not wrap.
- **Tie:** equal counts give `response = 0`. Both saturated also gives 0.
- **Busy handling:** `start` while busy is ignored. `challenge` and `win_len` changes while busy have no effect.
- **Held values:** `sel_a`/`sel_b` hold their value after `done` until the next accepted `start`. `response` and the counts hold until the next `done`.
- **Reset:** asynchronous `rst` in any state → IDLE, counters cleared. A measurement in progress is aborted and produces no `done`.
- **Output reset values:** `sel_a=0`, `sel_b=0`, `busy=0`, `done=0`, `response=0`, `count_a=0`, `count_b=0`.

## Timing
- `start` is sampled at edge T. From T+1: `busy=1`, `sel_*` hold the new values, state is SETTLE.
- COUNT spans cycles T+1+S … T+S+W, where S = SETTLE_CYC and W = `win_len`.
- COMPARE occurs at T+S+W+1.
- `done=1`, `busy=0` and the new results appear at T+S+W+2. Latency from `start` to `done` is S+W+2 cycles.
- A `start` asserted during the `done` cycle is accepted, because the FSM is in IDLE. Back-to-back measurements therefore have no idle gap.
- Edges are counted with 3-cycle synchronizer latency. Both channels share the same latency, so the comparison is unbiased.
- The maximum countable input rate is one rising edge per 2 `clk` cycles. Faster inputs undercount, and the block does not flag this.

## Structure
- Shared package `ro_puf_pkg` holds:
  - the FSM state enum (IDLE, SETTLE, COUNT, COMPARE);
  - the challenge field constants (SEL_A_LSB=0, SEL_B_LSB=3, SEL_W=3).
- Sub-module `ro_edge_counter` contains the synchronizer, the edge detect, and a saturating counter with `clr` and `en`. It is instantiated twice, once per channel.
- The top level holds the FSM, the window counter, the challenge/selection registers, and the comparator.

## Test plan
- **Reset values:** assert `rst` mid-simulation → all outputs 0 immediately (asynchronous), before the next `clk` edge.
- **A faster than B:** `challenge=6'b010_001`, A toggling with period 4 clk, B with period 8 clk, `win_len=64`, S=4 → `sel_a=1`, `sel_b=2`, `done` at T+70, `count_a=16`, `count_b=8`, `response=1`.
- **Swap and tie:**
  - Same stimulus with the frequencies swapped → `response=0`, counts 8/16.
  - Both channels at period 4 → counts 16/16, `response=0`.
- **Saturation:** `CNT_W=4`, A at period 2, B at period 4, `win_len=40` → `count_a=15` (saturated), `count_b=10`, `response=1`.
- **Zero window:** `win_len=0` → `done` at T+6 with both counts 0 and `response=0`.
- **Abort and re-trigger:**
  - A second `start` with a different challenge during COUNT → ignored; the result matches the first challenge.
  - `rst` during COUNT → no `done`. A fresh `start` afterwards completes normally.
